pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 84 ++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, taken-jump redirect with a one-cycle flush bubble.
// Optional taken-jump counter on the branch_count port when PC_BRANCH_COUNT_EN is defined.
module pc_unit #(
    parameter int unsigned          WIDTH        = 16,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_load,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic             fetch_valid,
    output logic             flush
`ifdef PC_BRANCH_COUNT_EN
    ,
    output logic [15:0]      branch_count
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRedirect
    } state_e;

    state_e state;

    assign pc_plus1 = pc + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            pc          <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
            branch_count <= 16'd0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    state       <= StRun;
                    fetch_valid <= 1'b1;
                    flush       <= 1'b0;
                end
                StRun: begin
                    // A taken jump wins over stall and fetch_ready.
                    if (pc_load) begin
                        state       <= StRedirect;
                        pc          <= branch_target;
                        fetch_valid <= 1'b0;
                        flush       <= 1'b1;
`ifdef PC_BRANCH_COUNT_EN
                        if (branch_count != 16'hFFFF) begin
                            branch_count <= branch_count + 16'd1;
                        end
`endif
                    end else begin
                        fetch_valid <= 1'b1;
                        flush       <= 1'b0;
                        if (fetch_ready && !stall) begin
                            pc <= pc_plus1;
                        end
                    end
                end
                StRedirect: begin
                    // pc_load held into this cycle is dropped, not queued.
                    state       <= StRun;
                    fetch_valid <= 1'b1;
                    flush       <= 1'b0;
                end
                default: begin
                    state       <= StIdle;
                    fetch_valid <= 1'b0;
                    flush       <= 1'b0;
                end
            endcase
        end
    end

endmodule
